axis_counter_checker: RTL

- AXI-Stream slave that consumes a free-running counter stream and checks that each beat equals the previous beat plus one, modulo 2^COUNTER_WIDTH.
- Sits at the sink end of a stream-test path, opposite the counter source, for loopback and DMA/FIFO integrity checks.
- Reports lock state, mismatch pulses, a saturating error count, a beat count and the last accepted value.

---
 rtl/axis_counter_checker_if.sv | 20 ++
 rtl/axis_counter_checker.sv | 108 ++++++++++
 2 files changed

// File: rtl/axis_counter_checker_if.sv
// AXI-Stream beat channel between a stream source and the counter checker.
interface axis_counter_checker_if #(
    parameter int DATA_WIDTH = 32
);
    logic                  tvalid;
    logic                  tready;
    logic [DATA_WIDTH-1:0] tdata;

    modport master (
        output tvalid,
        output tdata,
        input  tready
    );

    modport slave (
        input  tvalid,
        input  tdata,
        output tready
    );
endinterface

// File: rtl/axis_counter_checker.sv
// Sink-side checker for a free-running counter stream: every beat must be
// the previous beat plus one, wrapping at 2^COUNTER_WIDTH.
module axis_counter_checker #(
    parameter int AXIS_TDATA_WIDTH  = 32,
    parameter int COUNTER_WIDTH     = 32,
    parameter int ERROR_COUNT_WIDTH = 16,
    parameter int BEAT_COUNT_WIDTH  = 32
) (
    input  logic                         aclk,
    input  logic                         aresetn,
    input  logic                         enable,
    input  logic                         clear,
    axis_counter_checker_if.slave        s_axis,
    output logic                         locked,
    output logic                         error,
    output logic [ERROR_COUNT_WIDTH-1:0] error_count,
    output logic [BEAT_COUNT_WIDTH-1:0]  beat_count,
    output logic [COUNTER_WIDTH-1:0]     last_data
);

    typedef enum logic [1:0] {
        UNLOCKED = 2'd0,
        LOCKED   = 2'd1,
        SLIP     = 2'd2
    } state_t;

    state_t                       state_q, state_d;
    logic                         tready_q;
    logic                         error_q, error_d;
    logic [COUNTER_WIDTH-1:0]     expected_q, expected_d;
    logic [COUNTER_WIDTH-1:0]     last_q, last_d;
    logic [ERROR_COUNT_WIDTH-1:0] ecnt_q, ecnt_d;
    logic [BEAT_COUNT_WIDTH-1:0]  beat_q, beat_d;

    logic                         accept;
    logic                         mismatch;
    logic [COUNTER_WIDTH-1:0]     d;

    assign d        = s_axis.tdata[COUNTER_WIDTH-1:0];
    assign accept   = s_axis.tvalid & tready_q;
    assign mismatch = (d != expected_q);

    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            tready_q   <= 1'b0;
            state_q    <= UNLOCKED;
            error_q    <= 1'b0;
            expected_q <= '0;
            last_q     <= '0;
            ecnt_q     <= '0;
            beat_q     <= '0;
        end else begin
            tready_q   <= enable;
            state_q    <= state_d;
            error_q    <= error_d;
            expected_q <= expected_d;
            last_q     <= last_d;
            ecnt_q     <= ecnt_d;
            beat_q     <= beat_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        error_d    = 1'b0;
        expected_d = expected_q;
        last_d     = last_q;
        ecnt_d     = ecnt_q;
        beat_d     = beat_q;
        // clear wins over a coincident beat: it is consumed but ignored
        if (clear) begin
            state_d    = UNLOCKED;
            expected_d = '0;
            last_d     = '0;
            ecnt_d     = '0;
            beat_d     = '0;
        end else if (accept) begin
            beat_d     = beat_q + BEAT_COUNT_WIDTH'(1);
            last_d     = d;
            expected_d = d + COUNTER_WIDTH'(1);
            unique case (state_q)
                UNLOCKED: state_d = LOCKED;
                LOCKED: begin
                    if (mismatch) begin
                        state_d = SLIP;
                        error_d = 1'b1;
                    end
                end
                SLIP: begin
                    if (mismatch) error_d = 1'b1;
                    else          state_d = LOCKED;
                end
                default: state_d = UNLOCKED;
            endcase
            if (error_d && (ecnt_q != '1)) begin
                ecnt_d = ecnt_q + ERROR_COUNT_WIDTH'(1);
            end
        end
    end

    assign s_axis.tready = tready_q;
    assign locked        = (state_q == LOCKED);
    assign error         = error_q;
    assign error_count   = ecnt_q;
    assign beat_count    = beat_q;
    assign last_data     = last_q;

endmodule
